mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential multiplier among NREQ requesters. It captures the winning requester's operands and drives the multiplier's operand and start inputs. It then waits for the multiplier's ready flag, applies the sign flag to the magnitude product and returns a signed result with a one-cycle response pulse. It sits between client blocks and the shared multiplier datapath.

---
 rtl/mult_arb_pkg.sv | 15 +
 rtl/mult_share_arbiter_rr_pick.sv | 32 +++
 rtl/mult_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE_W,
    RUN_W,
    RESP
  } arb_state_e;

  localparam int unsigned SETTLE_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF = 64;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int unsigned j;

  // Scan NREQ slots starting at ptr; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among
// NREQ requesters; applies the sign flag to the magnitude product.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NBits   = 8,
  parameter int N2Bits  = 2 * NBits,
  parameter int NREQ    = 2,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*NBits-1:0]  req_multiplier,
  input  logic [NREQ*NBits-1:0]  req_multiplicand,
  output logic [NREQ-1:0]        req_grant,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [N2Bits-1:0]      rsp_product,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   mul_start,
  output logic [NBits-1:0]       mul_multiplier,
  output logic [NBits-1:0]       mul_multiplicand,
  input  logic [N2Bits-1:0]      mul_product,
  input  logic                   mul_ready,
  input  logic                   mul_sign
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  arb_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NBits-1:0]   mplier_q, mplier_d;
  logic [NBits-1:0]   mcand_q, mcand_d;
  logic [N2Bits-1:0]  res_q, res_d;
  logic               err_q, err_d;

  logic [NREQ-1:0]    pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign mul_multiplier   = mplier_q;
  assign mul_multiplicand = mcand_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and outputs. Grant is gated by reset so every output
  // reads 0 while reset is held, even with requests pending.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    res_d       = res_q;
    err_d       = err_q;
    req_grant   = '0;
    rsp_valid   = '0;
    rsp_product = '0;
    rsp_error   = 1'b0;
    mul_start   = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (pick_any && reset) begin
          req_grant = pick_gnt;
          sel_d     = pick_idx;
          mplier_d  = req_multiplier[pick_idx*NBits +: NBits];
          mcand_d   = req_multiplicand[pick_idx*NBits +: NBits];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        mul_start = 1'b1;
        cnt_d     = CW'(SETTLE - 1);
        state_d   = SETTLE_W;
      end
      SETTLE_W: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(TIMEOUT - 1);
          state_d = RUN_W;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN_W: begin
        if (mul_ready) begin
          res_d   = (mul_sign && (mul_product != '0)) ? (~mul_product + 1'b1) : mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid[sel_q] = 1'b1;
        rsp_product      = res_q;
        rsp_error        = err_q;
        ptr_d            = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        mplier_d         = '0;
        mcand_d          = '0;
        cnt_d            = '0;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural mock multiplier.
module tb_mult_share_arbiter;

  localparam int NBits   = 8;
  localparam int N2Bits  = 16;
  localparam int NREQ    = 2;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*NBits-1:0] req_multiplier;
  logic [NREQ*NBits-1:0] req_multiplicand;
  logic [NREQ-1:0]       req_grant;
  logic [NREQ-1:0]       rsp_valid;
  logic [N2Bits-1:0]     rsp_product;
  logic                  rsp_error;
  logic                  busy;
  logic                  mul_start;
  logic [NBits-1:0]      mul_multiplier;
  logic [NBits-1:0]      mul_multiplicand;
  logic [N2Bits-1:0]     mul_product;
  logic                  mul_ready;
  logic                  mul_sign;

  mult_share_arbiter #(
    .NBits   (NBits),
    .N2Bits  (N2Bits),
    .NREQ    (NREQ),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .req_valid        (req_valid),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .req_grant        (req_grant),
    .rsp_valid        (rsp_valid),
    .rsp_product      (rsp_product),
    .rsp_error        (rsp_error),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .mul_ready        (mul_ready),
    .mul_sign         (mul_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- mock multiplier ----------------
  // mode 0: ready once SETTLE+1 cycles after start; 1: ready stuck high; 2: stuck low
  int mode = 0;
  int mcnt = 0;
  int ia, ib;

  always @(posedge clk) begin
    if (mul_start) mcnt <= 1;
    else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
  end

  always_comb begin
    ia = int'($signed(mul_multiplier));
    ib = int'($signed(mul_multiplicand));
    if (ia < 0) ia = -ia;
    if (ib < 0) ib = -ib;
    mul_product = 16'(ia * ib);
    mul_sign    = mul_multiplier[7] ^ mul_multiplicand[7];
  end

  assign mul_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (mcnt >= SETTLE + 1);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0] onehot;
    logic [7:0] a;
    logic [7:0] b;
    logic       b2b;
  } gexp_t;

  typedef struct {
    logic [1:0]  onehot;
    logic [15:0] prod;
    logic        err;
    int          lat;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t cur;
  rexp_t r;
  int cyc = 0;
  int gcyc = 0;
  int last_rsp = 0;
  int nstart = 0;

  logic [7:0] op_a [2];
  logic [7:0] op_b [2];
  int ptr_m = 0;

  function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p);
  endfunction

  // Monitor: compares DUT grants/responses against the queued expectations.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rsp_valid == '0) check("rsp_quiet", {15'd0, rsp_error, rsp_product}, 32'd0);
      if (!busy) check("ops_idle", {16'd0, mul_multiplier, mul_multiplicand}, 32'd0);
      if (mul_start) begin
        nstart++;
        check("start_ops", {16'd0, mul_multiplier, mul_multiplicand}, {16'd0, cur.a, cur.b});
      end
      if (req_grant != '0) begin
        if (gq.size() == 0) check("grant_unexp", {30'd0, req_grant}, 32'd0);
        else begin
          cur = gq.pop_front();
          check("grant", {30'd0, req_grant}, {30'd0, cur.onehot});
          check("busy_at_grant", {31'd0, busy}, 32'd0);
          if (cur.b2b) check("gap", cyc - last_rsp, 1);
          gcyc   = cyc;
          nstart = 0;
        end
      end
      if (rsp_valid != '0) begin
        if (rq.size() == 0) check("rsp_unexp", {30'd0, rsp_valid}, 32'd0);
        else begin
          r = rq.pop_front();
          check("rsp_valid", {30'd0, rsp_valid}, {30'd0, r.onehot});
          check("rsp_product", {16'd0, rsp_product}, {16'd0, r.prod});
          check("rsp_error", {31'd0, rsp_error}, {31'd0, r.err});
          check("latency", cyc - gcyc, r.lat);
          check("start_count", nstart, 1);
          last_rsp = cyc;
        end
      end
    end
  end

  // Drive a set of requests, each held until granted, and queue expectations.
  task automatic serve(input logic [1:0] mask);
    logic [1:0] m, pending, g;
    logic first;
    int s;
    gexp_t ge;
    rexp_t re;
    m = mask;
    first = 1'b1;
    while (m != 2'b00) begin
      s = m[ptr_m] ? ptr_m : 1 - ptr_m;
      ge.onehot = 2'b01 << s;
      ge.a = op_a[s];
      ge.b = op_b[s];
      ge.b2b = !first;
      re.onehot = ge.onehot;
      if (mode == 2) begin
        re.prod = 16'h0000; re.err = 1'b1; re.lat = 2 + SETTLE + TIMEOUT;
      end else begin
        re.prod = exp_prod(op_a[s], op_b[s]); re.err = 1'b0; re.lat = 3 + SETTLE;
      end
      gq.push_back(ge);
      rq.push_back(re);
      first = 1'b0;
      m[s] = 1'b0;
      ptr_m = (s + 1) % 2;
    end
    @(posedge clk); #1;
    req_multiplier   = {op_a[1], op_a[0]};
    req_multiplicand = {op_b[1], op_b[0]};
    req_valid = mask;
    pending   = mask;
    for (int t = 0; t < 2000 && pending != 2'b00; t++) begin
      @(negedge clk);
      g = req_grant;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      pending   = pending & ~g;
    end
    check("grant_wait", {30'd0, pending}, 32'd0);
    for (int t = 0; t < 300 && rq.size() != 0; t++) @(negedge clk);
    check("rsp_wait", rq.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    gexp_t ge;
    int t;
    rst_n = 1'b0;
    req_valid = '0;
    req_multiplier = '0;
    req_multiplicand = '0;
    cur = '{onehot: 2'b00, a: 8'h00, b: 8'h00, b2b: 1'b0};
    repeat (2) @(negedge clk);
    check("reset_ctl", {25'd0, req_grant, rsp_valid, rsp_error, busy, mul_start}, 32'd0);
    check("reset_data", {mul_multiplier, mul_multiplicand, rsp_product}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesters after reset: slot 0 first, then slot 1 back-to-back.
    mode = 0;
    op_a[0] = 8'h07; op_b[0] = 8'h09;
    op_a[1] = 8'h80; op_b[1] = 8'h02;
    serve(2'b11);

    // Single request, negative product.
    op_a[0] = 8'h05; op_b[0] = 8'hFD;
    serve(2'b01);

    // Both again: pointer now favours slot 1.
    op_a[0] = 8'h03; op_b[0] = 8'h04;
    op_a[1] = 8'hFF; op_b[1] = 8'hFF;
    serve(2'b11);

    // Stale ready flag held high through LAUNCH and SETTLE_W.
    mode = 1;
    op_a[1] = 8'h04; op_b[1] = 8'h08;
    serve(2'b10);

    // Timeout, then a normal operation.
    mode = 2;
    op_a[0] = 8'h11; op_b[0] = 8'h22;
    serve(2'b01);
    mode = 0;
    op_a[0] = 8'hF0; op_b[0] = 8'hF0;
    serve(2'b01);

    // Zero magnitude with sign set.
    op_a[0] = 8'h00; op_b[0] = 8'hFD;
    serve(2'b01);

    // Reset during RUN_W on a slot-1 operation.
    mode = 2;
    op_a[1] = 8'h12; op_b[1] = 8'h34;
    ge = '{onehot: 2'b10, a: 8'h12, b: 8'h34, b2b: 1'b0};
    gq.push_back(ge);
    @(posedge clk); #1;
    req_multiplier   = {op_a[1], op_a[0]};
    req_multiplicand = {op_b[1], op_b[0]};
    req_valid = 2'b10;
    t = 0;
    while (t < 100 && req_grant == '0) begin
      @(negedge clk);
      t++;
    end
    check("abort_grant_wait", {31'd0, (req_grant == '0)}, 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (SETTLE + 5) @(posedge clk);
    #2;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl", {25'd0, req_grant, rsp_valid, rsp_error, busy, mul_start}, 32'd0);
    check("async_reset_data", {mul_multiplier, mul_multiplicand, rsp_product}, 32'd0);
    rq.delete();
    ptr_m = 0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("no_rsp_after_reset", {30'd0, rsp_valid}, 32'd0);
    end

    // Pointer back at 0: slot 0 wins, then a fresh slot-1 request.
    op_a[0] = 8'h7F; op_b[0] = 8'h7F;
    op_a[1] = 8'h81; op_b[1] = 8'h7F;
    serve(2'b11);
    op_a[1] = 8'h0A; op_b[1] = 8'hF6;
    serve(2'b10);

    repeat (3) @(negedge clk);
    check("queues_empty", gq.size() + rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
